// File: rtl/ship_move_ctrl.sv
// Player ship move sequencer: per frame, erases the 11x11 box at the old x and redraws it at the new x.
// Define SHIP_WRAP_EN to wrap the ship across the screen edges instead of clamping it there.
module ship_move_ctrl #(
    parameter int         BOX_SIZE = 11,
    parameter logic [7:0] X_START  = 8'd14,
    parameter logic [6:0] Y_POS    = 7'd99,
    parameter logic [7:0] X_MIN    = 8'd0,
    parameter logic [7:0] X_MAX    = 8'd149,
    parameter logic [7:0] STEP     = 8'd1,
    parameter logic [2:0] FG_COL   = 3'b111,
    parameter logic [2:0] BG_COL   = 3'b000
) (
    input  logic       clk,
    input  logic       reset_N,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int PIX = BOX_SIZE * BOX_SIZE;
    localparam int CW  = ($clog2(PIX) > 7) ? $clog2(PIX) : 7;
    localparam logic [CW-1:0] CNT_LAST = CW'(PIX - 1);

    typedef enum logic [2:0] {INIT, IDLE, ERASE, UPDATE, DRAW} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    nx, nx_d, x_d, target_x;
    logic [2:0]    colour_d;
    logic          plot_d, busy_d;
    logic          go_left, go_right;

    // Candidate origin for this frame; equals x_pos when no move should happen.
    always_comb begin
        go_left  = move_left & ~move_right;
        go_right = move_right & ~move_left;
        target_x = x_pos;
        if (go_left) begin
            if (x_pos < X_MIN + STEP) begin
`ifdef SHIP_WRAP_EN
                target_x = X_MAX;
`else
                target_x = X_MIN;
`endif
            end else begin
                target_x = x_pos - STEP;
            end
        end else if (go_right) begin
            if (x_pos > X_MAX - STEP) begin
`ifdef SHIP_WRAP_EN
                target_x = X_MIN;
`else
                target_x = X_MAX;
`endif
            end else begin
                target_x = x_pos + STEP;
            end
        end
    end

    // Output registers follow the current state, so each phase appears on the pins one cycle later.
    always_comb begin
        state_d  = state;
        cnt_d    = '0;
        nx_d     = nx;
        x_d      = x_pos;
        plot_d   = 1'b0;
        busy_d   = (state != IDLE);
        colour_d = BG_COL;
        case (state)
            INIT: begin
                state_d = DRAW;
            end
            IDLE: begin
                if (frame_tick && (target_x != x_pos)) begin
                    nx_d    = target_x;
                    state_d = ERASE;
                end
            end
            ERASE: begin
                plot_d = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            UPDATE: begin
                x_d     = nx;
                state_d = DRAW;
            end
            DRAW: begin
                plot_d   = 1'b1;
                colour_d = FG_COL;
                if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state  <= INIT;
            cnt    <= '0;
            nx     <= X_START;
            x_pos  <= X_START;
            y_pos  <= Y_POS;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            nx     <= nx_d;
            x_pos  <= x_d;
            y_pos  <= Y_POS;
            colour <= colour_d;
            plot   <= plot_d;
            busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Directed bench for ship_move_ctrl: expected plot runs are queued per move and checked as the DUT plots.
// Honours SHIP_WRAP_EN in its edge model when the design is built with it.
module tb_ship_move_ctrl;

    localparam int         PIX     = 121;
    localparam logic [7:0] X_START = 8'd14;
    localparam logic [7:0] X_MIN   = 8'd0;
    localparam logic [7:0] X_MAX   = 8'd149;
    localparam logic [7:0] STEP    = 8'd1;
    localparam logic [6:0] Y_POS   = 7'd99;

    logic       clk = 1'b0;
    logic       reset_N, frame_tick, move_left, move_right;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [2:0] colour;
    logic       plot, busy;

    ship_move_ctrl dut (
        .clk        (clk),
        .reset_N    (reset_N),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [2:0] col;
    } run_t;

    run_t       exp_q[$];
    run_t       exp_run;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [7:0] x_model;
    bit         in_run = 1'b0;
    logic [7:0] run_x;
    logic [2:0] run_col;
    int         run_len;
    bit         run_ok;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Collect each contiguous plot run and compare it against the oldest queued expectation.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_x   = x_pos;
                run_col = colour;
                run_len = 1;
                run_ok  = (y_pos === Y_POS);
            end else begin
                run_len++;
                if (x_pos !== run_x || colour !== run_col || y_pos !== Y_POS) run_ok = 1'b0;
            end
        end else if (in_run) begin
            in_run = 1'b0;
            checkOutput("run_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_run = exp_q.pop_front();
                checkOutput("run_x", run_x, exp_run.x);
                checkOutput("run_colour", run_col, exp_run.col);
                checkOutput("run_length", run_len, PIX);
                checkOutput("run_stable", run_ok, 1);
            end
        end
    end

    // One frame tick with the given buttons; queues the erase/draw pair if the model says the ship moves.
    task automatic applyStimulus(input logic l, input logic r);
        logic [7:0] nx;
        bit         moves;
        nx = x_model;
        if (l && !r) begin
            if (x_model < X_MIN + STEP) begin
`ifdef SHIP_WRAP_EN
                nx = X_MAX;
`else
                nx = X_MIN;
`endif
            end else nx = x_model - STEP;
        end else if (r && !l) begin
            if (x_model > X_MAX - STEP) begin
`ifdef SHIP_WRAP_EN
                nx = X_MIN;
`else
                nx = X_MAX;
`endif
            end else nx = x_model + STEP;
        end
        moves = (nx != x_model);
        if (moves) begin
            exp_q.push_back(run_t'{x: x_model, col: 3'b000});
            exp_q.push_back(run_t'{x: nx, col: 3'b111});
        end
        move_left  = l;
        move_right = r;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        checkOutput("erase_latency_plot", plot, moves);
        if (moves) x_model = nx;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600 && busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_idle"}, busy, 0);
        @(negedge clk); #1;
        checkOutput({tag, "_runs_drained"}, exp_q.size(), 0);
        checkOutput({tag, "_x"}, x_pos, x_model);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_N    = 1'b0;
        frame_tick = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        x_model    = X_START;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_plot", plot, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_x", x_pos, X_START);
        checkOutput("reset_y", y_pos, Y_POS);
        checkOutput("reset_colour", colour, 0);

        // Initial draw after reset release
        exp_q.push_back(run_t'{x: X_START, col: 3'b111});
        reset_N = 1'b1;
        @(posedge clk); #1;
        checkOutput("init_plot", plot, 0);
        checkOutput("init_busy", busy, 1);
        @(posedge clk); #1;
        checkOutput("init_draw_plot", plot, 1);
        checkOutput("init_draw_colour", colour, 7);
        wait_idle("init");

        applyStimulus(1'b0, 1'b1);
        wait_idle("right");
        applyStimulus(1'b1, 1'b1);
        wait_idle("both");
        applyStimulus(1'b0, 1'b0);
        wait_idle("none");

        // Second tick and a button flip during ERASE must be ignored
        applyStimulus(1'b0, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        move_left  = 1'b1;
        move_right = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        checkOutput("mid_erase_busy", busy, 1);
        wait_idle("mid_erase");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("mid_erase_no_second", busy, 0);

        while (x_model != X_MIN) begin
            applyStimulus(1'b1, 1'b0);
            wait_idle("walk_left");
        end
        applyStimulus(1'b1, 1'b0);
        wait_idle("left_edge");

        while (x_model != X_MAX) begin
            applyStimulus(1'b0, 1'b1);
            wait_idle("walk_right");
        end
        applyStimulus(1'b0, 1'b1);
        wait_idle("right_edge");

        // Reset at draw cycle 60 of a move away from the start position
        applyStimulus(1'b1, 1'b0);
        repeat (PIX + 1 + 60) @(posedge clk);
        #1;
        checkOutput("pre_reset_plot", plot, 1);
        checkOutput("pre_reset_colour", colour, 7);
        @(negedge clk); #1;
        reset_N = 1'b0;
        in_run  = 1'b0;
        exp_q.delete();
        x_model = X_START;
        @(posedge clk); #1;
        checkOutput("mid_reset_plot", plot, 0);
        checkOutput("mid_reset_x", x_pos, X_START);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_colour", colour, 0);
        @(posedge clk); #1;
        exp_q.push_back(run_t'{x: X_START, col: 3'b111});
        reset_N = 1'b1;
        @(posedge clk); #1;
        checkOutput("restart_init_busy", busy, 1);
        checkOutput("restart_init_plot", plot, 0);
        wait_idle("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
